// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and the scan evaluation helper for the
// 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS    = 4;
  localparam int KP_COLS    = 4;
  localparam int KP_KEYS    = KP_ROWS * KP_COLS;
  localparam int KP_CODE_W  = 4;
  localparam int KP_STATE_W = KP_CODE_W + 1;

  // Stable-state encoding: {1'b0, code} for a key, MSB set for "no key".
  localparam logic [KP_STATE_W-1:0] KP_NONE    = 5'b10000;
  localparam logic [KP_ROWS-1:0]    KP_ROW_RST = 4'b1110;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_PEND = 1'b1
  } evt_state_e;

  typedef struct packed {
    logic                  multi;
    logic [KP_STATE_W-1:0] cand;
  } scan_eval_t;

  // Reduce a full-scan press map to a candidate: one key -> its code,
  // no key -> KP_NONE, two or more keys -> multi (ghosting, scan invalid).
  function automatic scan_eval_t kp_eval(input logic [KP_KEYS-1:0] map);
    scan_eval_t r;
    int         n;
    n      = 0;
    r.cand = KP_NONE;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (map[i]) begin
        n++;
        r.cand = {1'b0, KP_CODE_W'(i)};
      end
    end
    r.multi = (n > 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_key_filter.sv
// keypad_key_filter: debounces full-scan candidates into a stable key state.
// A change is accepted after DEBOUNCE_SCANS consecutive identical valid scans
// that differ from the current stable state; ghosted scans clear the count.
module keypad_key_filter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_done,
  input  logic                  multi,
  input  logic [KP_STATE_W-1:0] candidate,
  output logic [KP_STATE_W-1:0] stable,
  output logic                  changed
);

  localparam logic [7:0] DEB_TC = 8'(DEBOUNCE_SCANS);

  logic [7:0]            cnt_q;
  logic [7:0]            cnt_nxt;
  logic [KP_STATE_W-1:0] prev_q;

  // Count value this scan would produce if the scan is valid.
  always_comb begin
    cnt_nxt = 8'd1;
    if ((candidate == prev_q) && (candidate != stable)) begin
      cnt_nxt = cnt_q + 8'd1;
    end
  end

  // Stable state, run counter and previous candidate, updated once per scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable  <= KP_NONE;
      prev_q  <= KP_NONE;
      cnt_q   <= 8'd0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (scan_done) begin
        if (multi) begin
          cnt_q <= 8'd0;
        end else begin
          prev_q <= candidate;
          if (cnt_nxt == DEB_TC) begin
            stable  <= candidate;
            cnt_q   <= 8'd0;
            changed <= (candidate != stable);
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scanner with column synchronizer,
// debounce filter and a single-entry valid/ready event output.
// Build option: KEYPAD_RELEASE_EVT_EN adds release events (key_release=1);
// without it only press events are produced and key_release stays 0.
//
// Event slot FSM:
//   state    | meaning
//   EVT_IDLE | no event pending, key_valid=0
//   EVT_PEND | event held on key_code/key_release, key_valid=1
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [KP_ROWS-1:0]   row_out,
  input  logic [KP_COLS-1:0]   col_in,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic                 key_release,
  output logic                 key_held,
  output logic                 overrun
);

  localparam int              SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SCAN_DIV - 1);

  logic [KP_COLS-1:0]    col_s1;
  logic [KP_COLS-1:0]    col_s2;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [1:0]            row_idx;
  logic [KP_KEYS-1:0]    press_map;
  logic                  scan_done;
  scan_eval_t            scan_ev;
  logic [KP_STATE_W-1:0] stable;
  logic                  changed;

  logic                  evt_new;
  logic [KP_CODE_W-1:0]  evt_code;
  logic                  evt_rel;

  evt_state_e            state_q;
  evt_state_e            state_d;
  logic                  evt_load;
  logic                  ovr_set;

  // Two-stage synchronizer; idle (pulled-up) level out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  // Row slot timer: down-counter per row, sample columns at terminal count,
  // then rotate to the next row; flag end of scan after row 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt  <= SLOT_LOAD;
      row_idx   <= 2'd0;
      row_out   <= KP_ROW_RST;
      press_map <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (slot_cnt == '0) begin
        press_map[{row_idx, 2'b00} +: KP_COLS] <= ~col_s2;
        row_idx   <= row_idx + 2'd1;
        row_out   <= {row_out[KP_ROWS-2:0], row_out[KP_ROWS-1]};
        slot_cnt  <= SLOT_LOAD;
        scan_done <= (row_idx == 2'd3);
      end else begin
        slot_cnt <= slot_cnt - 1'b1;
      end
    end
  end

  assign scan_ev = kp_eval(press_map);

  keypad_key_filter #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_key_filter (
    .clk       (clk),
    .rst       (rst),
    .scan_done (scan_done),
    .multi     (scan_ev.multi),
    .candidate (scan_ev.cand),
    .stable    (stable),
    .changed   (changed)
  );

  assign key_held = (stable != KP_NONE);

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [KP_CODE_W-1:0] held_code;

  // Remember the accepted key so its code can be reported on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_code <= '0;
    end else if (changed && (stable != KP_NONE)) begin
      held_code <= stable[KP_CODE_W-1:0];
    end
  end

  // Every accepted transition is an event; a transition to none is a release.
  always_comb begin
    evt_new  = changed;
    evt_code = stable[KP_CODE_W-1:0];
    evt_rel  = 1'b0;
    if (stable == KP_NONE) begin
      evt_code = held_code;
      evt_rel  = 1'b1;
    end
  end
`else
  // Only transitions onto a key are events.
  always_comb begin
    evt_new  = changed && (stable != KP_NONE);
    evt_code = stable[KP_CODE_W-1:0];
    evt_rel  = 1'b0;
  end
`endif

  // Event slot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EVT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event slot next state: load when empty or draining this cycle, else drop.
  always_comb begin
    state_d  = state_q;
    evt_load = 1'b0;
    ovr_set  = 1'b0;
    case (state_q)
      EVT_IDLE: begin
        if (evt_new) begin
          evt_load = 1'b1;
          state_d  = EVT_PEND;
        end
      end
      EVT_PEND: begin
        if (key_ready) begin
          if (evt_new) begin
            evt_load = 1'b1;
          end else begin
            state_d = EVT_IDLE;
          end
        end else if (evt_new) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = EVT_IDLE;
    endcase
  end

  assign key_valid = (state_q == EVT_PEND);

  // Event payload and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code    <= '0;
      key_release <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (evt_load) begin
        key_code    <= evt_code;
        key_release <= evt_rel;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
